// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 encodings, default widths and small helpers for the slave write path.
package axi4_globals_pkg;

    localparam int ADDRESS_WIDTH          = 32;
    localparam int DATA_WIDTH             = 32;
    localparam int STROBE_WIDTH           = DATA_WIDTH / 8;
    localparam int OUTSTANDING_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        BURST_FIXED    = 2'b00,
        BURST_INCR     = 2'b01,
        BURST_WRAP     = 2'b10,
        BURST_RESERVED = 2'b11
    } awburst_e;

    typedef enum logic [2:0] {
        SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B
    } awsize_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    typedef enum logic [1:0] {IDLE, LOAD, DATA, RESP} wr_state_e;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    // The encoding order already matches severity (DECERR > SLVERR > OKAY).
    function automatic bresp_e worse_resp(input bresp_e a, input bresp_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_sync_fifo.sv
// Single-clock FIFO with show-ahead head, full/empty flags and occupancy count.
module axi4_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define validity,
    // and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge aclk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write responder: buffers AW, walks W beats onto a byte-strobed memory
// port and returns one in-order B response per burst.
module axi4_slave_write_responder #(
    parameter int                       ADDRESS_WIDTH          = axi4_globals_pkg::ADDRESS_WIDTH,
    parameter int                       DATA_WIDTH             = axi4_globals_pkg::DATA_WIDTH,
    parameter int                       OUTSTANDING_FIFO_DEPTH = axi4_globals_pkg::OUTSTANDING_FIFO_DEPTH,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS            = ADDRESS_WIDTH'(32'h0000_0000),
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS            = ADDRESS_WIDTH'(32'h0000_2FFF)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [3:0]                awid,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic [3:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [3:0]                bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

    import axi4_globals_pkg::*;

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int COUNT_W = $clog2(OUTSTANDING_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [3:0]               id;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [3:0]               len;
        awsize_e                  size;
        awburst_e                 burst;
    } aw_req_t;

    aw_req_t                  aw_in;
    aw_req_t                  fifo_head;
    aw_req_t                  req;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [COUNT_W-1:0]       fifo_count;

    wr_state_e                state;
    wr_state_e                next_state;

    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ADDRESS_WIDTH-1:0] inc;
    logic [ADDRESS_WIDTH-1:0] size_mask;
    logic [ADDRESS_WIDTH-1:0] wrap_mask;
    logic [ADDRESS_WIDTH-1:0] next_addr;
    logic [3:0]               beat_cnt;
    bresp_e                   err;
    bresp_e                   beat_err;
    logic                     pre_err;
    logic                     pre_err_c;
    logic                     in_range;
    logic                     len_match;
    logic                     burst_end;
    logic                     w_hs;

    assign aw_in = '{id: awid, addr: awaddr, len: awlen,
                     size: awsize_e'(awsize), burst: awburst_e'(awburst)};

    assign awready   = !areset && !fifo_full;
    assign fifo_push = awvalid && awready;
    assign w_hs      = wready && wvalid;
    assign bvalid    = (state == RESP);
    assign bid       = req.id;
    assign bresp     = err;

    axi4_sync_fifo #(
        .WIDTH ($bits(aw_req_t)),
        .DEPTH (OUTSTANDING_FIFO_DEPTH)
    ) u_aw_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (fifo_push),
        .push_data (aw_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    fifo_flags_consistent: assert property (@(posedge aclk) disable iff (areset)
        fifo_full == (fifo_count == COUNT_W'(OUTSTANDING_FIFO_DEPTH)));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of a combinational block gets a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        wready     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: next_state = DATA;
            DATA: begin
                wready = 1'b1;
                if (wvalid && burst_end) next_state = RESP;
            end
            RESP: if (bready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        inc       = ADDRESS_WIDTH'(1) << req.size;
        size_mask = inc - ADDRESS_WIDTH'(1);
        wrap_mask = ((ADDRESS_WIDTH'(req.len) + ADDRESS_WIDTH'(1)) << req.size) - ADDRESS_WIDTH'(1);
        case (req.burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + inc) & wrap_mask);
            default:     next_addr = addr + inc;
        endcase

        pre_err_c = (req.burst == BURST_RESERVED)
                 || (inc > ADDRESS_WIDTH'(STRB_W))
                 || ((req.burst == BURST_WRAP)
                     && (!wrap_len_ok(req.len) || ((req.addr & size_mask) != '0)));

        // One unsigned compare covers both bounds: below MIN wraps to a huge offset.
        in_range  = (addr - MIN_ADDRESS) <= (MAX_ADDRESS - MIN_ADDRESS);
        len_match = (beat_cnt == req.len);
        burst_end = wlast || len_match;
        beat_err  = in_range ? RESP_OKAY : RESP_DECERR;
        if (burst_end && (wlast != len_match)) beat_err = worse_resp(beat_err, RESP_SLVERR);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            req       <= '0;
            addr      <= '0;
            beat_cnt  <= '0;
            err       <= RESP_OKAY;
            pre_err   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: if (fifo_pop) req <= fifo_head;
                LOAD: begin
                    addr     <= req.addr;
                    beat_cnt <= '0;
                    pre_err  <= pre_err_c;
                    err      <= pre_err_c ? RESP_SLVERR : RESP_OKAY;
                end
                DATA: begin
                    if (w_hs) begin
                        mem_we    <= in_range && !pre_err;
                        mem_addr  <= addr & ~size_mask;
                        mem_wdata <= wdata;
                        mem_wstrb <= wstrb;
                        beat_cnt  <= beat_cnt + 4'd1;
                        addr      <= next_addr;
                        err       <= worse_resp(err, beat_err);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Directed bench for the AXI4 slave write responder; expected values are hand-computed.
module tb_axi4_slave_write_responder;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    always #5 aclk = ~aclk;

    axi4_slave_write_responder dut (
        .aclk      (aclk),
        .areset    (areset),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    wire [77:0] out_bus = {awready, wready, bvalid, mem_we, bid, bresp,
                           mem_addr, mem_wdata, mem_wstrb};

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

    wr_t wr_q[$];
    b_t  b_q[$];
    int  checks = 0;
    int  passed = 0;

    // Observe on the falling edge, half a cycle away from every DUT update.
    always @(negedge aclk) begin
        if (mem_we === 1'b1) wr_q.push_back('{mem_addr, mem_wdata, mem_wstrb});
        if (bvalid === 1'b1 && bready === 1'b1) b_q.push_back('{bid, bresp});
    end

    function automatic wr_t wr_at(input int i);
        wr_t none = '{32'hx, 32'hx, 4'hx};
        return (i < wr_q.size()) ? wr_q[i] : none;
    endfunction

    function automatic b_t b_at(input int i);
        b_t none = '{4'hx, 2'hx};
        return (i < b_q.size()) ? b_q[i] : none;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok = 1'b0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge aclk);
            ok = awready;
            step();
        end
        awvalid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL aw_handshake id=%0h awready never high within 50 cycles", id);
        end
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok = 1'b0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge aclk);
            ok = wready;
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL w_handshake data=%h wready never high within 50 cycles", data);
        end
    endtask

    task automatic wait_b(input int n);
        int k = 0;
        while (b_q.size() < n && k < 300) begin
            step();
            k++;
        end
        if (b_q.size() < n) begin
            checks++;
            $display("FAIL b_timeout got=%0d responses required=%0d", b_q.size(), n);
        end
    endtask

    // Beat i of a burst carries data 0xD000_<id><i>; wlast is set on beat last_at.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int nbeats, input int last_at);
        wr_q.delete();
        b_q.delete();
        bready = 1'b1;
        send_aw(id, addr, len, size, burst);
        for (int i = 0; i < nbeats; i++)
            send_w(32'hD000_0000 | {20'd0, id, 8'(i)}, 4'hF, i == last_at);
        wait_b(1);
        repeat (2) step();
    endtask

    task automatic test_reset();
        areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (out_bus !== '0) $display("FAIL reset_outputs got=%h required=0", out_bus);
        else passed++;
        step();
        areset = 1'b0;
        @(negedge aclk);
        checks++;
        if (awready !== 1'b1) $display("FAIL reset_awready got=%b required=1", awready);
        else passed++;
        checks++;
        if ({wready, bvalid, mem_we} !== 3'b000)
            $display("FAIL reset_idle got wready/bvalid/mem_we=%b required=000", {wready, bvalid, mem_we});
        else passed++;
        step();
    endtask

    task automatic test_incr();
        wr_t w;
        b_t  b;
        run_burst(4'h3, 32'h100, 4'd3, 3'd2, 2'b01, 4, 3);
        checks++;
        if (wr_q.size() != 4) $display("FAIL incr_count got=%0d required=4", wr_q.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            w = wr_at(i);
            checks++;
            if ({w.addr, w.data, w.strb} !== {32'h100 + 32'(4 * i), 32'hD000_0300 + 32'(i), 4'hF})
                $display("FAIL incr_beat%0d got addr=%h data=%h strb=%h required addr=%h data=%h strb=f",
                         i, w.addr, w.data, w.strb, 32'h100 + 32'(4 * i), 32'hD000_0300 + 32'(i));
            else passed++;
        end
        b = b_at(0);
        checks++;
        if ({b.id, b.resp} !== {4'h3, 2'b00})
            $display("FAIL incr_bresp got id=%h resp=%b required id=3 resp=00", b.id, b.resp);
        else passed++;
    endtask

    task automatic test_wrap_fixed();
        logic [31:0] exp_wrap [4];
        wr_t w;
        b_t  b;
        exp_wrap = '{32'h108, 32'h10C, 32'h100, 32'h104};
        run_burst(4'h5, 32'h108, 4'd3, 3'd2, 2'b10, 4, 3);
        checks++;
        if (wr_q.size() != 4) $display("FAIL wrap_count got=%0d required=4", wr_q.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            w = wr_at(i);
            checks++;
            if (w.addr !== exp_wrap[i])
                $display("FAIL wrap_addr%0d got=%h required=%h", i, w.addr, exp_wrap[i]);
            else passed++;
        end
        b = b_at(0);
        checks++;
        if ({b.id, b.resp} !== {4'h5, 2'b00})
            $display("FAIL wrap_bresp got id=%h resp=%b required id=5 resp=00", b.id, b.resp);
        else passed++;

        run_burst(4'h6, 32'h20, 4'd2, 3'd2, 2'b00, 3, 2);
        checks++;
        if (wr_q.size() != 3) $display("FAIL fixed_count got=%0d required=3", wr_q.size());
        else passed++;
        for (int i = 0; i < 3; i++) begin
            w = wr_at(i);
            checks++;
            if (w.addr !== 32'h20) $display("FAIL fixed_addr%0d got=%h required=00000020", i, w.addr);
            else passed++;
        end
        b = b_at(0);
        checks++;
        if ({b.id, b.resp} !== {4'h6, 2'b00})
            $display("FAIL fixed_bresp got id=%h resp=%b required id=6 resp=00", b.id, b.resp);
        else passed++;
    endtask

    task automatic test_slverr();
        b_t b;
        // Reserved burst type: beats accepted, nothing written.
        run_burst(4'h7, 32'h40, 4'd1, 3'd2, 2'b11, 2, 1);
        b = b_at(0);
        checks++;
        if ({wr_q.size() == 0, b.id, b.resp} !== {1'b1, 4'h7, 2'b10})
            $display("FAIL reserved_burst got writes=%0d id=%h resp=%b required writes=0 id=7 resp=10",
                     wr_q.size(), b.id, b.resp);
        else passed++;
        // Early wlast on beat 1 of a 4-beat burst.
        run_burst(4'h8, 32'h200, 4'd3, 3'd2, 2'b01, 2, 1);
        b = b_at(0);
        checks++;
        if ({wr_q.size() == 2, b.id, b.resp, wready} !== {1'b1, 4'h8, 2'b10, 1'b0})
            $display("FAIL early_wlast got writes=%0d id=%h resp=%b wready=%b required writes=2 id=8 resp=10 wready=0",
                     wr_q.size(), b.id, b.resp, wready);
        else passed++;
        // Missing wlast: the burst still ends on the awlen count.
        run_burst(4'h2, 32'h300, 4'd1, 3'd2, 2'b01, 2, -1);
        b = b_at(0);
        checks++;
        if ({wr_q.size() == 2, b.id, b.resp} !== {1'b1, 4'h2, 2'b10})
            $display("FAIL missing_wlast got writes=%0d id=%h resp=%b required writes=2 id=2 resp=10",
                     wr_q.size(), b.id, b.resp);
        else passed++;
        // 8-byte beats on a 4-byte bus.
        run_burst(4'h4, 32'h80, 4'd0, 3'd3, 2'b01, 1, 0);
        b = b_at(0);
        checks++;
        if ({wr_q.size() == 0, b.id, b.resp} !== {1'b1, 4'h4, 2'b10})
            $display("FAIL oversize got writes=%0d id=%h resp=%b required writes=0 id=4 resp=10",
                     wr_q.size(), b.id, b.resp);
        else passed++;
    endtask

    task automatic test_decerr();
        wr_t w;
        b_t  b;
        run_burst(4'h9, 32'h2FFC, 4'd1, 3'd2, 2'b01, 2, 1);
        w = wr_at(0);
        checks++;
        if ({wr_q.size() == 1, w.addr} !== {1'b1, 32'h2FFC})
            $display("FAIL decerr_writes got count=%0d addr0=%h required count=1 addr0=00002ffc",
                     wr_q.size(), w.addr);
        else passed++;
        b = b_at(0);
        checks++;
        if ({b.id, b.resp} !== {4'h9, 2'b11})
            $display("FAIL decerr_bresp got id=%h resp=%b required id=9 resp=11", b.id, b.resp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ids [17];
        int         blocked = 0;
        b_t         b;
        wr_q.delete();
        b_q.delete();
        bready = 1'b0;
        // One AW is popped into the engine, so 17 fit before the FIFO reports full.
        for (int i = 0; i < 17; i++) begin
            ids[i] = 4'((i * 5 + 1) % 16);
            send_aw(ids[i], 32'h400 + 32'(4 * i), 4'd0, 3'd2, 2'b01);
        end
        @(negedge aclk);
        checks++;
        if (awready !== 1'b0) $display("FAIL fifo_full_awready got=%b required=0", awready);
        else passed++;
        awid = 4'hE; awaddr = 32'h800; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            if (awready === 1'b0) blocked++;
            step();
        end
        awvalid = 1'b0;
        checks++;
        if (blocked != 4) $display("FAIL fifo_full_hold got blocked=%0d required=4", blocked);
        else passed++;

        send_w(32'hB000_0000, 4'hF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            checks++;
            if ({bvalid, wready, bid, bresp} !== {1'b1, 1'b0, ids[0], 2'b00})
                $display("FAIL b_hold%0d got bvalid=%b wready=%b bid=%h bresp=%b required 1 0 %h 00",
                         k, bvalid, wready, bid, bresp, ids[0]);
            else passed++;
        end
        step();
        bready = 1'b1;
        for (int i = 1; i < 17; i++) send_w(32'hB000_0000 + 32'(i), 4'hF, 1'b1);
        wait_b(17);
        repeat (2) step();
        checks++;
        if ({b_q.size() == 17, wr_q.size() == 17} !== 2'b11)
            $display("FAIL b2b_counts got b=%0d writes=%0d required 17 17", b_q.size(), wr_q.size());
        else passed++;
        for (int i = 0; i < 17; i++) begin
            b = b_at(i);
            checks++;
            if ({b.id, b.resp} !== {ids[i], 2'b00})
                $display("FAIL b2b_order%0d got id=%h resp=%b required id=%h resp=00", i, b.id, b.resp, ids[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_burst();
        int  stale = 0;
        wr_t w;
        b_t  b;
        b_q.delete();
        bready = 1'b1;
        send_aw(4'hA, 32'h500, 4'd3, 3'd2, 2'b01);
        send_aw(4'hB, 32'h600, 4'd0, 3'd2, 2'b01);
        send_w(32'hC0DE_0000, 4'hF, 1'b0);
        send_w(32'hC0DE_0001, 4'hF, 1'b0);
        areset = 1'b1;
        #1;
        checks++;
        if (out_bus !== '0) $display("FAIL midburst_reset_outputs got=%h required=0", out_bus);
        else passed++;
        repeat (2) step();
        areset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (wready !== 1'b0 || bvalid !== 1'b0) stale++;
            step();
        end
        checks++;
        if ({stale == 0, b_q.size() == 0, awready} !== 3'b111)
            $display("FAIL midburst_flush got stale=%0d b=%0d awready=%b required 0 0 1",
                     stale, b_q.size(), awready);
        else passed++;
        run_burst(4'hC, 32'h700, 4'd0, 3'd2, 2'b01, 1, 0);
        w = wr_at(0);
        b = b_at(0);
        checks++;
        if ({b.id, b.resp, wr_q.size() == 1, w.addr} !== {4'hC, 2'b00, 1'b1, 32'h700})
            $display("FAIL post_reset_burst got id=%h resp=%b writes=%0d addr=%h required id=c resp=00 writes=1 addr=00000700",
                     b.id, b.resp, wr_q.size(), w.addr);
        else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_incr();
        test_wrap_fixed();
        test_slverr();
        test_decerr();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
